// File: rtl/ws2812_frame_feeder_if.sv
// Host/driver bundle for the ws2812 frame feeder: buffer writes, commit,
// and the paced per-LED stream toward the ws2812 driver.
interface ws2812_frame_feeder_if;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [23:0] cfg_data;
  logic [7:0]  brightness;
  logic        commit;
  logic [23:0] rgb_data;
  logic [7:0]  led_num;
  logic        write;
  logic        busy;
  logic        done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, brightness, commit,
    input  rgb_data, led_num, write, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, brightness, commit,
    output rgb_data, led_num, write, busy, done
  );
endinterface

// File: rtl/ws2812_frame_feeder.sv
// Per-LED colour buffer plus sequencer that streams the whole buffer to a
// ws2812 driver, one paced write per LED, with global brightness scaling.
module ws2812_frame_feeder #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned WRITE_GAP = 4
) (
  input logic clk,
  input logic reset,
  ws2812_frame_feeder_if.slave bus
);

  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned GW = $clog2(WRITE_GAP + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, GAP} state_e;

  state_e        state_q;
  logic [7:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic          pend_q;
  logic [7:0]    bright_q;
  logic [23:0]   rgb_q;
  logic [7:0]    led_q;
  logic          write_q;
  logic          busy_q;
  logic          done_q;

  logic [23:0]   buf_q [NUM_LEDS];
  logic          buf_we_c;
  logic [23:0]   word_c;
  logic [23:0]   scaled_c;
  logic [8:0]    mult_c;

  // (c * (brightness + 1)) >> 8 on a 16-bit product
  function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [8:0] m);
    return 8'((16'(c) * 16'(m)) >> 8);
  endfunction

  assign buf_we_c = bus.cfg_we && (9'(bus.cfg_addr) < 9'(NUM_LEDS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LEDS; i++) buf_q[i] <= '0;
    end else if (buf_we_c) begin
      buf_q[AW'(bus.cfg_addr)] <= bus.cfg_data;
    end
  end

  always_comb begin
    word_c   = buf_q[AW'(idx_q)];
    mult_c   = {1'b0, bright_q} + 9'd1;
    scaled_c = {scale_byte(word_c[23:16], mult_c),
                scale_byte(word_c[15:8],  mult_c),
                scale_byte(word_c[7:0],   mult_c)};
  end

  // Sequencer: FETCH reads/scales one entry, SEND pulses write, GAP paces.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      gap_q    <= '0;
      pend_q   <= 1'b0;
      bright_q <= 8'hFF;
      rgb_q    <= '0;
      led_q    <= '0;
      write_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      if (bus.commit && (state_q != IDLE)) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.commit) begin
            bright_q <= bus.brightness;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= FETCH;
          end
        end
        FETCH: begin
          rgb_q   <= scaled_c;
          led_q   <= idx_q;
          state_q <= SEND;
        end
        SEND: begin
          write_q <= 1'b1;
          gap_q   <= GW'(WRITE_GAP);
          state_q <= GAP;
        end
        GAP: begin
          if (gap_q == GW'(1)) begin
            if (9'(idx_q) < 9'(NUM_LEDS - 1)) begin
              idx_q   <= idx_q + 8'd1;
              state_q <= FETCH;
            end else begin
              done_q <= 1'b1;
              // A commit seen during the frame (or on its last cycle) restarts at once
              if (pend_q || bus.commit) begin
                pend_q   <= 1'b0;
                bright_q <= bus.brightness;
                idx_q    <= '0;
                state_q  <= FETCH;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end
            end
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rgb_data = rgb_q;
  assign bus.led_num  = led_q;
  assign bus.write    = write_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_ws2812_frame_feeder.sv
// Scoreboard bench: a timeline model of frames predicts each LED write,
// done pulse and busy level; a negedge monitor pops and compares.
module tb_ws2812_frame_feeder;
  localparam int N = 8;
  localparam int W = 4;
  localparam int P = W + 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ws2812_frame_feeder_if bus();

  ws2812_frame_feeder #(.NUM_LEDS(N), .WRITE_GAP(W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    int          idx;
    logic [23:0] val;
    int          edge_n;
  } exp_t;

  exp_t        expq[$];
  exp_t        mx;
  exp_t        my;
  logic [23:0] mbuf [N];
  logic [7:0]  mbright = 8'hFF;
  bit          m_active = 0, m_pend = 0, m_busy = 0, m_done = 0;
  int          ecnt = 0, s = 0, d = 0;
  int          checks = 0, errors = 0;

  function automatic logic [23:0] scale(input logic [23:0] v, input logic [7:0] b);
    int r, g, bl;
    r  = (int'(v[23:16]) * (int'(b) + 1)) / 256;
    g  = (int'(v[15:8])  * (int'(b) + 1)) / 256;
    bl = (int'(v[7:0])   * (int'(b) + 1)) / 256;
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Frame timeline: LED i fetched at start+1+i*P, written one edge later, done at start+N*P
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      foreach (mbuf[i]) mbuf[i] = '0;
      m_active = 0; m_pend = 0; m_busy = 0; m_done = 0;
      mbright = 8'hFF;
      expq.delete();
    end else begin
      ecnt++;
      m_done = 0;
      if (m_active) begin
        d = ecnt - s;
        if (d >= 1 && (d - 1) % P == 0 && (d - 1) / P < N) begin
          mx.idx = (d - 1) / P;
          mx.val = scale(mbuf[mx.idx], mbright);
          mx.edge_n = ecnt + 1;
          expq.push_back(mx);
        end
        if (d == N * P) begin
          m_done = 1;
          if (m_pend || bus.commit) begin
            s = ecnt; mbright = bus.brightness; m_pend = 0;
          end else begin
            m_active = 0;
          end
        end else if (bus.commit) begin
          m_pend = 1;
        end
      end else if (bus.commit) begin
        m_active = 1; s = ecnt; mbright = bus.brightness;
      end
      if (bus.cfg_we && int'(bus.cfg_addr) < N) mbuf[bus.cfg_addr] = bus.cfg_data;
      m_busy = m_active;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(bus.busy), 32'(m_busy));
      chk("done", 32'(bus.done), 32'(m_done));
      if (bus.write) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write led_num=%0d rgb=%0h required=none", bus.led_num, bus.rgb_data);
        end else begin
          my = expq.pop_front();
          chk("led_num", 32'(bus.led_num), 32'(my.idx));
          chk("rgb_data", 32'(bus.rgb_data), 32'(my.val));
          chk("write_edge", 32'(ecnt), 32'(my.edge_n));
        end
      end else if (expq.size() > 0 && ecnt >= expq[0].edge_n) begin
        my = expq.pop_front();
        checks++; errors++;
        $display("FAIL missing_write actual=none required=led%0d", my.idx);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [23:0] v);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = v;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic do_commit(input logic [7:0] b);
    bus.brightness = b; bus.commit = 1'b1;
    @(negedge clk);
    bus.commit = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!bus.busy && !m_busy && !m_pend) break;
      @(negedge clk);
    end
    chk("idle_timeout_busy", 32'(bus.busy), 32'(0));
    cyc(2);
  endtask

  initial begin
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.brightness = 8'hFF; bus.commit = 1'b0;
    reset = 1'b1;
    cyc(3);
    chk("rst_rgb", 32'(bus.rgb_data), 32'(0));
    chk("rst_led", 32'(bus.led_num), 32'(0));
    chk("rst_write", 32'(bus.write), 32'(0));
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    reset = 1'b0;
    cyc(2);

    // Zero buffer at full brightness
    do_commit(8'hFF);
    wait_idle();

    // Scaling
    wr(8'd3, 24'h00FF80);
    do_commit(8'h80);
    wait_idle();
    do_commit(8'h00);
    wait_idle();

    // Out-of-range writes are dropped
    wr(8'd8, 24'h123456);
    wr(8'd255, 24'h654321);
    do_commit(8'hFF);
    wait_idle();

    // Commits during a frame collapse into one follow-on frame
    for (int i = 0; i < N; i++) wr(8'(i), 24'($urandom));
    do_commit(8'hFF);
    cyc(10);
    do_commit(8'h40);
    cyc(5);
    do_commit(8'hC0);
    wait_idle();

    // Mid-frame writes: ahead of the fetch pointer vs already sent
    wr(8'd0, 24'h222222);
    do_commit(8'hFF);
    cyc(16);
    wr(8'd7, 24'hABCDEF);
    wr(8'd0, 24'h111111);
    wait_idle();
    do_commit(8'hFF);
    wait_idle();

    // Write and commit on the same cycle in IDLE
    bus.cfg_we = 1'b1; bus.cfg_addr = 8'd0; bus.cfg_data = 24'h5A5A5A;
    bus.commit = 1'b1; bus.brightness = 8'hFF;
    @(negedge clk);
    bus.cfg_we = 1'b0; bus.commit = 1'b0;
    wait_idle();

    // Reset in the gap after LED 4
    do_commit(8'hFF);
    cyc(2 + 4 * P + 1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_write", 32'(bus.write), 32'(0));
    chk("midrst_busy", 32'(bus.busy), 32'(0));
    chk("midrst_done", 32'(bus.done), 32'(0));
    chk("midrst_rgb", 32'(bus.rgb_data), 32'(0));
    cyc(3);
    reset = 1'b0;
    cyc(40);
    do_commit(8'hFF);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      bus.cfg_we     = ($urandom % 3) == 0;
      bus.cfg_addr   = 8'($urandom % 11);
      bus.cfg_data   = 24'($urandom);
      bus.brightness = 8'($urandom);
      bus.commit     = ($urandom % 40) == 0;
      @(negedge clk);
    end
    bus.cfg_we = 1'b0; bus.commit = 1'b0;
    wait_idle();

    chk("leftover_expected_writes", 32'(expq.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ws2812_frame_feeder.md
Name: ws2812_frame_feeder

Overview:
Frame buffer and sequencer that sits directly upstream of the ws2812 driver. Host logic, such as a wishbone register bank or a user project, writes per-LED 24-bit colours into a local buffer and then pulses commit. The block then streams every LED to the driver's rgb_data/led_num/write inputs, one paced single-cycle write per LED, with optional global brightness scaling.

Parameters:
NUM_LEDS, 8, number of LEDs in the buffer (1..256)
WRITE_GAP, 4, idle cycles inserted after each write pulse (>=1)

Ports:
clk  input  1  system clock (12 MHz, same as ws2812)
reset  input  1  asynchronous, active-high reset
cfg_we  input  1  buffer write strobe, one cycle per word
cfg_addr  input  8  LED index for cfg_we
cfg_data  input  24  colour word, stored as written; byte order is passed through unchanged
brightness  input  8  global scale, sampled on accepted commit
commit  input  1  single-cycle request to stream the whole buffer
rgb_data  output  24  colour to ws2812, registered
led_num  output  8  LED index to ws2812, registered
write  output  1  single-cycle write strobe to ws2812, registered
busy  output  1  high from accepted commit until the end of the frame
done  output  1  single-cycle pulse after the last LED is sent

Behaviour:
- Reset, async: buffer entries=0; rgb_data=0, led_num=0, write=0, busy=0, done=0; state=IDLE; pending=0; latched brightness=0xFF; index=0.
- Buffer write: on cfg_we with cfg_addr<NUM_LEDS, buf[cfg_addr]<=cfg_data at the clock edge. Writes are accepted in any state. Writes with cfg_addr>=NUM_LEDS are silently ignored.
- States: IDLE, FETCH, SEND, GAP.
- IDLE: commit=1 -> latch brightness, index=0, busy=1, go to FETCH.
- FETCH (1 cycle): compute each byte c of buf[index] as (c*(brightness+1))>>8, using a 16-bit product and keeping bits [15:8]. brightness=0xFF therefore passes data unchanged, and 0x00 gives (c+1... no: c*1>>8) = 0 for all c. Load rgb_data and led_num=index. Go to SEND.
- SEND (1 cycle): write=1. Go to GAP with gap counter=WRITE_GAP.
- GAP: write=0; decrement the counter each cycle. When the counter reaches 0:
  - if index<NUM_LEDS-1: index++, go to FETCH;
  - else: done=1 for one cycle and return to IDLE.
  - busy drops to 0 in the same cycle done is high, unless pending is set.
- Timing: a commit sampled at edge k gives write high in the cycle after edge k+2. Write-to-write period is WRITE_GAP+2 cycles. Frame length is NUM_LEDS*(WRITE_GAP+2) cycles from commit to done.
- Data snapshot: each LED's value is read in its own FETCH cycle. A write to an LED not yet fetched appears in the current frame; a write to an LED already sent does not.
- Commit while busy: sets pending=1; multiple commits collapse into one. At frame end, done still pulses, busy stays 1, brightness is re-latched, index=0, and the FSM goes straight to FETCH.
- Simultaneous cfg_we and commit in IDLE: the write lands first, so the new value is used for that LED.
- rgb_data and led_num hold their last values between writes. The downstream driver only samples them when write=1.
- Reset mid-frame clears everything immediately, including pending and the buffer. No further write pulse is emitted.

Test Plan:
- Reset then commit with brightness=0xFF, NUM_LEDS=8, WRITE_GAP=4, buffer 0 -> 8 write pulses spaced 6 cycles apart, led_num 0..7, rgb_data=0; done pulses 48 cycles after commit; busy is high throughout.
- Write buf[3]=0x00FF80, brightness=0x80, commit -> led_num=3 write carries 0x008040 (0xFF*0x81>>8=0x80, 0x80*0x81>>8=0x40); brightness=0x00 -> 0x000000.
- Write cfg_addr=8 with 0x123456, then commit -> no buffer entry changes; all eight outputs show their prior values.
- Commit twice during a frame -> exactly one extra frame follows with no IDLE cycle in between; done pulses twice in total; busy stays high across the boundary.
- Mid-frame, write buf[7]=0xABCDEF after LED 2 is sent, and buf[0]=0x111111 -> LED 7 shows 0xABCDEF and LED 0 shows the old value in this frame; the next frame shows 0x111111 on LED 0.
- Assert reset during the GAP after LED 4 -> write/busy/done go to 0 immediately; no further write pulses appear; a subsequent commit streams all zeros.
